// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state codes, PC constants,
// the IF/ID payload layout and small address helpers.
// Optional feature macro used by this slice: FETCH_PERF_EN (fetch/stall counters).
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch-stage state codes
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [XLEN-1:0] PC_INC       = 32'd4;
    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:   BUBBLE_INSTR,
        pc:      32'h0,
        pc_next: 32'h0,
        valid:   1'b0
    };

    // Sequential PC, wrapping modulo 2^32
    function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

    // Branch targets are forced onto a word boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with load enable and target / +4 next-PC select.
// Holding is expressed by leaving load_en low.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_d;

    // Next-PC mux: aligned branch target or sequential increment
    always_comb begin
        pc_d = pc_add4(pc);
        if (sel_target) begin
            pc_d = word_align(target);
        end
    end

    // PC register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, drives the
// combinational ROM address, and handles stall, flush and branch redirect.
// Optional feature macro: FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc_next,
    output logic              if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [31:0] pc;
    logic        pc_load;
    logic        pc_sel_tgt;
    logic        ifid_load;
    if_id_t      ifid_d;
    if_id_t      ifid_q;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_en    (pc_load),
        .sel_target (pc_sel_tgt),
        .target     (br_target),
        .pc         (pc)
    );

    // ROM address follows the PC with no latency, wrapping at 2^ADDR_W
    assign imem_addr = pc[ADDR_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC control and IF/ID next value; rules in priority order
    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        pc_sel_tgt = 1'b0;
        ifid_load  = 1'b0;
        ifid_d     = IF_ID_BUBBLE;
        case (state_q)
            ST_BOOT: begin
                // One settling cycle: PC held, bubble into IF/ID
                state_d   = ST_RUN;
                ifid_load = 1'b1;
            end
            default: begin
                if (br_taken) begin
                    pc_load    = 1'b1;
                    pc_sel_tgt = 1'b1;
                    ifid_load  = 1'b1;
                end else if (stall) begin
                    ifid_load = flush;
                end else if (flush) begin
                    pc_load   = 1'b1;
                    ifid_load = 1'b1;
                end else begin
                    pc_load   = 1'b1;
                    ifid_load = 1'b1;
                    ifid_d    = '{
                        instr:   imem_data,
                        pc:      pc,
                        pc_next: pc_add4(pc),
                        valid:   1'b1
                    };
                end
            end
        endcase
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_q <= IF_ID_BUBBLE;
        end else if (ifid_load) begin
            ifid_q <= ifid_d;
        end
    end

    assign if_id_instr   = ifid_q.instr;
    assign if_id_pc      = ifid_q.pc;
    assign if_id_pc_next = ifid_q.pc_next;
    assign if_id_valid   = ifid_q.valid;

`ifdef FETCH_PERF_EN
    logic fetch_win;
    logic stall_win;

    assign fetch_win = ifid_load & ifid_d.valid;
    assign stall_win = (state_q == ST_RUN) & ~br_taken & stall;

    // Saturating fetch and stall counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (fetch_win && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall_win && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a byte-addressed big-endian ROM model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_next;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] rom [256];

    fetch_stage #(
        .ADDR_W   (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_next (if_id_pc_next),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian word read, byte addresses wrap inside the 256-byte ROM
    assign imem_data = {rom[imem_addr], rom[8'(imem_addr + 8'd1)],
                        rom[8'(imem_addr + 8'd2)], rom[8'(imem_addr + 8'd3)]};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a[7:0] == 8'h00) return 32'hE3A0_0001;
        if (a[7:0] == 8'h04) return 32'hE3A0_1002;
        return 32'hE100_0000 | {24'h0, a[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pcn, input logic v);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc"}, if_id_pc, pc);
        chk({tag, ".pc_next"}, if_id_pc_next, pcn);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = word_at(32'(i * 4));
            rom[i*4]   = w[31:24];
            rom[i*4+1] = w[23:16];
            rom[i*4+2] = w[15:8];
            rom[i*4+3] = w[7:0];
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst.addr", 32'(imem_addr), 32'h00);
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
        chk("rst.fcnt", fetch_count, 32'd0);
        chk("rst.scnt", stall_count, 32'd0);
`endif

        // BOOT edge: PC held, bubble
        reset = 1'b1;
        tick();
        chk("boot.addr", 32'(imem_addr), 32'h00);
        chk("boot.valid", 32'(if_id_valid), 32'd0);

        // First valid fetch
        tick();
        chk_ifid("f0", 32'hE3A0_0001, 32'h0, 32'h4, 1'b1);
        chk("f0.addr", 32'(imem_addr), 32'h04);
        tick();
        chk_ifid("f4", 32'hE3A0_1002, 32'h4, 32'h8, 1'b1);
        chk("f4.addr", 32'(imem_addr), 32'h08);

        // Stall three cycles at PC=8
        stall = 1'b1;
        tick(); tick(); tick();
        chk("stl.addr", 32'(imem_addr), 32'h08);
        chk_ifid("stl", 32'hE3A0_1002, 32'h4, 32'h8, 1'b1);
`ifdef FETCH_PERF_EN
        chk("stl.scnt", stall_count, 32'd3);
        chk("stl.fcnt", fetch_count, 32'd2);
`endif
        stall = 1'b0;
        tick();
        chk_ifid("f8", word_at(32'h8), 32'h8, 32'hC, 1'b1);

        // Flush during stall at PC=0xC
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("sf.addr", 32'(imem_addr), 32'h0C);
        chk_ifid("sf", 32'h0, 32'h0, 32'h0, 1'b0);
        stall = 1'b0; flush = 1'b0;
        tick();
        chk_ifid("fC", word_at(32'hC), 32'hC, 32'h10, 1'b1);

        // Plain flush advances PC and inserts a bubble
        flush = 1'b1;
        tick();
        chk("fl.addr", 32'(imem_addr), 32'h14);
        chk("fl.valid", 32'(if_id_valid), 32'd0);
        flush = 1'b0;

        // Branch overrides stall, target aligned
        br_taken = 1'b1; br_target = 32'h23; stall = 1'b1;
        tick();
        chk("br.addr", 32'(imem_addr), 32'h20);
        chk("br.valid", 32'(if_id_valid), 32'd0);
`ifdef FETCH_PERF_EN
        chk("br.scnt", stall_count, 32'd4);
`endif
        br_taken = 1'b0; stall = 1'b0;
        tick();
        chk_ifid("f20", word_at(32'h20), 32'h20, 32'h24, 1'b1);
`ifdef FETCH_PERF_EN
        chk("f20.fcnt", fetch_count, 32'd5);
`endif

        // ROM address wrap at 0xFC -> 0x100
        br_taken = 1'b1; br_target = 32'hFC;
        tick();
        br_taken = 1'b0;
        tick();
        chk_ifid("fFC", word_at(32'hFC), 32'hFC, 32'h100, 1'b1);
        chk("wrap.addr", 32'(imem_addr), 32'h00);
        tick();
        chk_ifid("f100", 32'hE3A0_0001, 32'h100, 32'h104, 1'b1);

        // 32-bit PC wrap
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        tick();
        chk("top.addr", 32'(imem_addr), 32'hFC);
        br_taken = 1'b0;
        tick();
        chk_ifid("ftop", word_at(32'hFC), 32'hFFFF_FFFC, 32'h0, 1'b1);
        tick();
        chk_ifid("fwr0", 32'hE3A0_0001, 32'h0, 32'h4, 1'b1);

        // Reset during a stall at PC=0x40 with a pending branch
        br_taken = 1'b1; br_target = 32'h40;
        tick();
        br_taken = 1'b0;
        stall = 1'b1;
        tick();
        chk("pre.addr", 32'(imem_addr), 32'h40);
        br_taken = 1'b1; br_target = 32'h80; reset = 1'b0;
        tick();
        chk("mr.addr", 32'(imem_addr), 32'h00);
        chk_ifid("mr", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
        chk("mr.fcnt", fetch_count, 32'd0);
        chk("mr.scnt", stall_count, 32'd0);
`endif
        reset = 1'b1; br_taken = 1'b0; stall = 1'b0;
        tick();
        chk("mrb.addr", 32'(imem_addr), 32'h00);
        chk("mrb.valid", 32'(if_id_valid), 32'd0);
        tick();
        chk_ifid("mrf", 32'hE3A0_0001, 32'h0, 32'h4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
